// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
//
// Purpose:
//   Word-addressed data memory behind the MEM stage of a pipelined CPU. Each
//   access may be stretched by WAIT_CYCLES stall cycles. The pipeline freezes
//   while mem_stall is high and holds its request stable. With WAIT_CYCLES=0
//   every access completes in the cycle it is presented.
//
// Parameters:
//   ADDR_WIDTH  - word-address width; the array holds 2^ADDR_WIDTH 32-bit words
//   WAIT_CYCLES - stall cycles per access (0..7)
//
// Ports:
//   clk       in   single clock, rising edge
//   rst       in   asynchronous, active-high reset
//   mem_ren   in   read request
//   mem_wen   in   write request (wins over mem_ren when both are high)
//   mem_addr  in   byte address; bits [ADDR_WIDTH+1:2] select the word
//   mem_dout  in   write data from the pipeline
//   mem_din   out  read data returned to the pipeline (holds the last read)
//   mem_stall out  high while a presented access is not yet complete
//   mem_err   out  misaligned-access flag for the completion cycle
//
// Optional feature:
//   `define MEM_ALIGN_CHECK_EN to flag accesses with mem_addr[1:0] != 0.
//   Such accesses raise mem_err, suppress the write and read back zero.
//   When the macro is not defined, mem_err is tied low and the low address
//   bits are ignored.
// ---------------------------------------------------------------------------
module data_mem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_din,
  output logic        mem_stall,
  output logic        mem_err
);

  localparam int       DEPTH     = 1 << ADDR_WIDTH;
  localparam bit       ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam bit       ONE_WAIT  = (WAIT_CYCLES == 1);
  localparam logic [2:0] CNT_LOAD = 3'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [31:0] din_q;

  logic [31:0] mem_array [0:DEPTH-1];

  logic                  req;
  logic                  is_read;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  misaligned;
  logic                  done_now;
  logic                  wr_commit;
  logic                  rd_capture;
  logic [31:0]           rd_word;
  logic                  unused_addr_bits;

  assign req     = mem_ren | mem_wen;
  assign is_read = mem_ren & ~mem_wen;
  assign idx     = mem_addr[ADDR_WIDTH+1:2];

  // Upper address bits are deliberately ignored so the array wraps.
  assign unused_addr_bits = ^{mem_addr[31:ADDR_WIDTH+2], mem_addr[1:0]};

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = |mem_addr[1:0];
`else
  assign misaligned = 1'b0;
`endif

  // The completion cycle is the presentation cycle when there are no wait
  // states, otherwise the DONE cycle with the request still held.
  assign done_now  = ZERO_WAIT ? req : ((state_q == DONE) && req);
  assign wr_commit = done_now && mem_wen && !misaligned && !rst;

  // Misaligned reads return zero rather than the addressed word.
  assign rd_word = misaligned ? 32'h0 : mem_array[idx];

  // Read data is captured on the edge that enters DONE, or on the edge that
  // ends a zero-wait read, so mem_din keeps it until the next read.
  assign rd_capture = ZERO_WAIT ? (req && is_read)
                                : ((state_q != DONE) && (state_d == DONE) && is_read);

  // State register and wait counter; reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. A single wait cycle goes straight to DONE because the
  // counter would already be at zero after loading. Dropping the request in
  // WAIT abandons the access without touching the array.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req && !ZERO_WAIT) begin
          if (ONE_WAIT) begin
            state_d = DONE;
            cnt_d   = 3'd0;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end else if (cnt_q <= 3'd1) begin
          state_d = DONE;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // Outputs. Stall is raised combinationally in the cycle a request first
  // appears in IDLE so the pipeline freezes immediately. Everything is forced
  // quiet while reset is held, even if a request is present.
  always_comb begin
    mem_stall = 1'b0;
    mem_err   = 1'b0;
    mem_din   = din_q;
    if (!rst) begin
      if (!ZERO_WAIT) begin
        mem_stall = ((state_q == IDLE) && req) || (state_q == WAIT);
      end
      mem_err = done_now && misaligned;
      if (ZERO_WAIT && req && is_read) begin
        mem_din = rd_word;
      end
    end else begin
      mem_din = 32'h0;
    end
  end

  // Read-data holding register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din_q <= 32'h0;
    end else if (rd_capture) begin
      din_q <= rd_word;
    end
  end

  // Storage array; its contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_commit) begin
      mem_array[idx] <= mem_dout;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_data_mem_responder
//
// Purpose:
//   Directed bench for data_mem_responder. Two instances share the clock and
//   reset: u_dut2 with WAIT_CYCLES=2 and u_dut0 with WAIT_CYCLES=0.
//   Inputs are driven 1 ns after the rising edge and outputs are observed a
//   further nanosecond later. Build with MEM_ALIGN_CHECK_EN defined to
//   exercise the misalignment flag.
// ---------------------------------------------------------------------------
module tb_data_mem_responder;

  logic        clk;
  logic        rst;

  logic        ren2, wen2;
  logic [31:0] addr2, dout2;
  logic [31:0] din2;
  logic        stall2, err2;

  logic        ren0, wen0;
  logic [31:0] addr0, dout0;
  logic [31:0] din0;
  logic        stall0, err0;

  int checks   = 0;
  int failures = 0;

  data_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) u_dut2 (
    .clk       (clk),
    .rst       (rst),
    .mem_ren   (ren2),
    .mem_wen   (wen2),
    .mem_addr  (addr2),
    .mem_dout  (dout2),
    .mem_din   (din2),
    .mem_stall (stall2),
    .mem_err   (err2)
  );

  data_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u_dut0 (
    .clk       (clk),
    .rst       (rst),
    .mem_ren   (ren0),
    .mem_wen   (wen0),
    .mem_addr  (addr0),
    .mem_dout  (dout0),
    .mem_din   (din0),
    .mem_stall (stall0),
    .mem_err   (err0)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, and on mismatch counts and reports the failure.
  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Move to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full access on the two-wait instance: stall in the presentation cycle and
  // the WAIT cycle, then the DONE cycle with its read data and error flag.
  task automatic apply_stimulus(input string tag, input logic ren, input logic wen,
                                input logic [31:0] addr, input logic [31:0] data,
                                input logic [31:0] exp_din, input logic exp_err);
    ren2  = ren;
    wen2  = wen;
    addr2 = addr;
    dout2 = data;
    #1;
    check_output({tag, "_stall_t0"}, {31'b0, stall2}, 32'd1);
    tick();
    check_output({tag, "_stall_t1"}, {31'b0, stall2}, 32'd1);
    check_output({tag, "_err_t1"},   {31'b0, err2},   32'd0);
    tick();
    check_output({tag, "_stall_done"}, {31'b0, stall2}, 32'd0);
    check_output({tag, "_din_done"},   din2,            exp_din);
    check_output({tag, "_err_done"},   {31'b0, err2},   {31'b0, exp_err});
    tick();
    ren2 = 1'b0;
    wen2 = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    ren2  = 1'b0; wen2 = 1'b0; addr2 = '0; dout2 = '0;
    ren0  = 1'b0; wen0 = 1'b0; addr0 = '0; dout0 = '0;

    // Reset values before any clock edge.
    #3;
    check_output("rst_stall2", {31'b0, stall2}, 32'd0);
    check_output("rst_din2",   din2,            32'h0);
    check_output("rst_err2",   {31'b0, err2},   32'd0);
    check_output("rst_stall0", {31'b0, stall0}, 32'd0);
    check_output("rst_din0",   din0,            32'h0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check_output("post_rst_stall2", {31'b0, stall2}, 32'd0);

    // Write then read back through the wait states.
    apply_stimulus("wr40", 1'b0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0, 1'b0);
    apply_stimulus("rd40", 1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 1'b0);
    #1;
    check_output("hold_after_rd40", din2, 32'hDEAD_BEEF);

    // Upper address bits wrap: 0x1004 and 0x0004 are the same word.
    apply_stimulus("wr1004", 1'b0, 1'b1, 32'h0000_1004, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0);
    apply_stimulus("rd0004", 1'b1, 1'b0, 32'h0000_0004, 32'h0, 32'h1234_5678, 1'b0);

    // Both requests high is a write and leaves mem_din alone.
    apply_stimulus("both80", 1'b1, 1'b1, 32'h0000_0080, 32'hA5A5_A5A5, 32'h1234_5678, 1'b0);
    apply_stimulus("rd80",   1'b1, 1'b0, 32'h0000_0080, 32'h0, 32'hA5A5_A5A5, 1'b0);

    // Dropping the request in WAIT aborts without writing.
    wen2 = 1'b1; addr2 = 32'h0000_0040; dout2 = 32'h7777_7777;
    #1;
    check_output("abort_stall_t0", {31'b0, stall2}, 32'd1);
    tick();
    wen2 = 1'b0;
    #1;
    check_output("abort_stall_wait", {31'b0, stall2}, 32'd1);
    tick();
    check_output("abort_stall_idle", {31'b0, stall2}, 32'd0);
    apply_stimulus("rd40_after_abort", 1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 1'b0);

    // Reset in the first WAIT cycle of a write keeps the old contents.
    apply_stimulus("wr8_old", 1'b0, 1'b1, 32'h0000_0008, 32'h2222_2222, 32'hDEAD_BEEF, 1'b0);
    wen2 = 1'b1; addr2 = 32'h0000_0008; dout2 = 32'h1111_1111;
    tick();
    rst = 1'b1;
    #1;
    check_output("midrst_stall", {31'b0, stall2}, 32'd0);
    check_output("midrst_din",   din2,            32'h0);
    wen2 = 1'b0;
    tick();
    rst = 1'b0;
    apply_stimulus("rd8_after_rst", 1'b1, 1'b0, 32'h0000_0008, 32'h0, 32'h2222_2222, 1'b0);

    // Zero-wait instance: completes in the presentation cycle.
    wen0 = 1'b1; addr0 = 32'h0000_0040; dout0 = 32'hDEAD_BEEF;
    #1;
    check_output("z_wr_stall", {31'b0, stall0}, 32'd0);
    check_output("z_wr_din",   din0,            32'h0);
    tick();
    wen0 = 1'b0; ren0 = 1'b1;
    #1;
    check_output("z_rd_din",   din0,            32'hDEAD_BEEF);
    check_output("z_rd_stall", {31'b0, stall0}, 32'd0);
    check_output("z_rd_err",   {31'b0, err0},   32'd0);
    tick();
    ren0 = 1'b0;
    #1;
    check_output("z_hold_din", din0, 32'hDEAD_BEEF);

`ifdef MEM_ALIGN_CHECK_EN
    // Misaligned write is flagged and dropped; misaligned read returns zero.
    apply_stimulus("mis_wr42", 1'b0, 1'b1, 32'h0000_0042, 32'h9999_9999, 32'h2222_2222, 1'b1);
    #1;
    check_output("mis_err_cleared", {31'b0, err2}, 32'd0);
    apply_stimulus("rd40_no_wr",  1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 1'b0);
    apply_stimulus("mis_rd42",    1'b1, 1'b0, 32'h0000_0042, 32'h0, 32'h0, 1'b1);
`else
    // Low address bits are ignored: 0x42 addresses the word at 0x40.
    apply_stimulus("lo_wr42", 1'b0, 1'b1, 32'h0000_0042, 32'h9999_9999, 32'h2222_2222, 1'b0);
    apply_stimulus("lo_rd40", 1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'h9999_9999, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
